tcb_infer_scheduler: RTL and testbench
======================================

// Module: tcb_infer_scheduler
// PURPOSE
//  Shares one TCB inference network (121-pixel 8-bit image in, 32-bit class out) between two image
//  requesters. Round-robin grant, latch of the granted image, start pulse to the network, wait for
//  its done pulse with a watchdog, and return of the result tagged with requester ID.
//  Sits between the image sources and the network top.
// PARAMETERS
//  IMG_W        968    image bus width (121 px x 8 bit)
//  TIMEOUT_CYC  4096   max cycles in BUSY before the job is aborted (>=2)
//  GUARD_CYC    64     cycles after a timeout during which net_ready is ignored (>=1)
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-low reset
//  req0_valid  in   1      requester 0 has an image
//  req0_img    in   IMG_W  requester 0 image
//  req0_ready  out  1      requester 0 image accepted this cycle
//  req1_valid  in   1      requester 1 has an image
//  req1_img    in   IMG_W  requester 1 image
//  req1_ready  out  1      requester 1 image accepted this cycle
//  net_img     out  IMG_W  image to network, held stable from LAUNCH through BUSY
//  net_valid   out  1      1-cycle start pulse to network
//  net_ready   in   1      network done pulse; net_number valid in the same cycle
//  net_number  in   32     network prediction
//  res_valid   out  1      result available, held until res_ready
//  res_ready   in   1      result consumer accepts
//  res_id      out  1      requester that owns the result
//  res_number  out  32     prediction; 32'hFFFF_FFFF on timeout
//  res_timeout out  1      result is a timeout abort
//  busy        out  1      high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, rr_ptr=0, all outputs 0, net_img=0, counters cleared.
//  FSM: IDLE -> LAUNCH -> BUSY -> RESULT -> IDLE; BUSY -> RESULT (timeout) -> GUARD -> IDLE.
//  IDLE: grant is combinational. Only one valid -> that one. Both valid -> requester rr_ptr.
//   reqN_ready = grant & reqN_valid, only in IDLE; never both high.
//   On accept: latch reqN_img into net_img, save id, rr_ptr <= ~id, go to LAUNCH.
//  LAUNCH: net_valid=1 for exactly this cycle; clear watchdog counter; go to BUSY.
//  BUSY: watchdog increments each cycle. net_ready=1 -> latch net_number and id,
//   res_timeout=0, go to RESULT. Watchdog reaches TIMEOUT_CYC-1 without net_ready ->
//   res_number=32'hFFFF_FFFF, res_timeout=1, go to RESULT.
//   Same cycle net_ready and timeout: net_ready wins (normal result).
//  RESULT: res_valid=1; res_id/res_number/res_timeout stable. On res_ready: res_valid=0 next
//   cycle; go to IDLE, or GUARD if res_timeout=1. No new grant while in RESULT.
//  GUARD: count GUARD_CYC cycles, then go to IDLE. net_ready is ignored here and in IDLE,
//   LAUNCH and RESULT, so a stray or late done pulse produces no result.
//  Latency: accept at cycle T -> net_valid at T+1 -> earliest res_valid at T+3, when net_ready
//   arrives at T+2.
//  Back-to-back: res_ready in cycle R -> IDLE at R+1 -> next accept possible at R+1.
//  net_img is only updated on accept, so the image is held while the network runs.
//  Reset mid-job: all state is dropped and the job is lost; no result and no start pulse is issued.
//  Width: watchdog counter is $clog2(TIMEOUT_CYC) bits and saturates. No other arithmetic.
// TESTING
//  T1 single job: req0_valid with img=all 8'h11; net_ready with net_number=7 three cycles after
//   net_valid -> net_valid one cycle at T+1; res_valid, res_id=0, res_number=7, res_timeout=0.
//  T2 contention: req0 and req1 valid together for 4 jobs, rr_ptr=0 after reset ->
//   grants in order 0,1,0,1; req0_ready and req1_ready never both high.
//  T3 timeout: TIMEOUT_CYC=16 and the network never responds -> res_valid 16 cycles after LAUNCH,
//   res_number=32'hFFFFFFFF, res_timeout=1; a net_ready pulse during GUARD produces no result.
//  T4 backpressure: hold res_ready=0 for 10 cycles while req1_valid=1 -> result held stable,
//   req1_ready stays 0; req1 accepted in the cycle after res_ready.
//  T5 race: net_ready in the same cycle the watchdog expires -> normal result, res_timeout=0.
//  T6 reset mid-BUSY: pull rst low for 1 cycle during BUSY -> all outputs 0 at once; no res_valid
//   follows; the next job starts cleanly with grant to requester 0.

Source files
------------

// File: rtl/tcb_infer_scheduler_if.sv
// Bundle of the requester, network and result handshakes around the TCB
// inference scheduler. The scheduler uses the slave view; the requesters,
// network model and result consumer together use the master view.
interface tcb_infer_scheduler_if #(
  parameter int IMG_W = 968
);
  // Requester 0
  logic             req0_valid;
  logic [IMG_W-1:0] req0_img;
  logic             req0_ready;
  // Requester 1
  logic             req1_valid;
  logic [IMG_W-1:0] req1_img;
  logic             req1_ready;
  // Inference network
  logic [IMG_W-1:0] net_img;
  logic             net_valid;
  logic             net_ready;
  logic [31:0]      net_number;
  // Result consumer
  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [31:0]      res_number;
  logic             res_timeout;
  // Status
  logic             busy;

  modport slave (
    input  req0_valid, req0_img, req1_valid, req1_img,
    input  net_ready, net_number, res_ready,
    output req0_ready, req1_ready, net_img, net_valid,
    output res_valid, res_id, res_number, res_timeout, busy
  );

  modport master (
    output req0_valid, req0_img, req1_valid, req1_img,
    output net_ready, net_number, res_ready,
    input  req0_ready, req1_ready, net_img, net_valid,
    input  res_valid, res_id, res_number, res_timeout, busy
  );
endinterface

// File: rtl/tcb_infer_scheduler.sv
// Shares one TCB inference network between two image requesters.
// Round-robin grant in IDLE, image latched on accept, one-cycle start pulse,
// watchdog on the done pulse, and a held result tagged with the requester id.
// After a timeout abort a guard window swallows any late done pulse.
module tcb_infer_scheduler #(
  parameter int IMG_W       = 968,
  parameter int TIMEOUT_CYC = 4096,
  parameter int GUARD_CYC   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  tcb_infer_scheduler_if.slave   bus
);

  localparam int WD_W = $clog2(TIMEOUT_CYC);
  localparam int GD_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_MAX  = '1;
  localparam logic [GD_W-1:0] GD_LAST = GD_W'(GUARD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_BUSY,
    ST_RESULT,
    ST_GUARD
  } state_t;

  state_t           state;
  logic             rr_ptr;
  logic             id_q;
  logic [WD_W-1:0]  wd_cnt;
  logic [GD_W-1:0]  gd_cnt;
  logic [IMG_W-1:0] net_img_q;
  logic             net_valid_q;
  logic             res_valid_q;
  logic             res_id_q;
  logic [31:0]      res_number_q;
  logic             res_timeout_q;

  // Grant: a lone requester always wins, a tie goes to rr_ptr. Readies are
  // only offered in IDLE and are held low while reset is asserted.
  logic in_idle;
  logic gnt0, gnt1;
  logic ready0, ready1;
  logic accept;

  assign in_idle = (state == ST_IDLE) && rst;
  assign gnt0    = bus.req0_valid && (!bus.req1_valid || !rr_ptr);
  assign gnt1    = bus.req1_valid && (!bus.req0_valid ||  rr_ptr);
  assign ready0  = in_idle && gnt0;
  assign ready1  = in_idle && gnt1;
  assign accept  = ready0 || ready1;

  // Watchdog advances by one and saturates; expiry is the cycle in which it
  // reaches its last value.
  logic [WD_W-1:0] wd_next;
  logic            wd_expire;

  assign wd_next   = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 1'b1;
  assign wd_expire = (wd_next == WD_LAST);

  // Scheduler FSM with registered start pulse and result outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      rr_ptr        <= 1'b0;
      id_q          <= 1'b0;
      wd_cnt        <= '0;
      gd_cnt        <= '0;
      // NOTE: the image register is a plain flop bank, not a RAM, so it can
      // and does clear on reset; a dropped job leaves no stale image behind.
      net_img_q     <= '0;
      net_valid_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_id_q      <= 1'b0;
      res_number_q  <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      net_valid_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            net_img_q   <= ready1 ? bus.req1_img : bus.req0_img;
            id_q        <= ready1;
            rr_ptr      <= ~ready1;
            net_valid_q <= 1'b1;
            state       <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          wd_cnt <= '0;
          state  <= ST_BUSY;
        end
        ST_BUSY: begin
          if (bus.net_ready) begin
            res_number_q  <= bus.net_number;
            res_id_q      <= id_q;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b1;
            state         <= ST_RESULT;
          end else if (wd_expire) begin
            res_number_q  <= 32'hFFFF_FFFF;
            res_id_q      <= id_q;
            res_timeout_q <= 1'b1;
            res_valid_q   <= 1'b1;
            state         <= ST_RESULT;
          end else begin
            wd_cnt <= wd_next;
          end
        end
        ST_RESULT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            gd_cnt      <= '0;
            state       <= res_timeout_q ? ST_GUARD : ST_IDLE;
          end
        end
        ST_GUARD: begin
          if (gd_cnt == GD_LAST) begin
            state <= ST_IDLE;
          end else begin
            gd_cnt <= gd_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.net_img     = net_img_q;
  assign bus.net_valid   = net_valid_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_id      = res_id_q;
  assign bus.res_number  = res_number_q;
  assign bus.res_timeout = res_timeout_q;
  assign bus.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_tcb_infer_scheduler.sv
// Directed bench for tcb_infer_scheduler: a table of complete jobs covering
// round-robin arbitration and latency, followed by hand-written sequences for
// timeout and guard, result backpressure, the done/timeout race and reset
// in the middle of a job.
module tb_tcb_infer_scheduler;

  localparam int IMG_W       = 968;
  localparam int TIMEOUT_CYC = 16;
  localparam int GUARD_CYC   = 4;

  localparam logic [IMG_W-1:0] IMG0 = {121{8'h11}};
  localparam logic [IMG_W-1:0] IMG1 = {121{8'h22}};

  logic clk = 1'b0;
  logic rst = 1'b0;

  tcb_infer_scheduler_if #(.IMG_W(IMG_W)) bus ();

  tcb_infer_scheduler #(
    .IMG_W       (IMG_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .GUARD_CYC   (GUARD_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [IMG_W-1:0] exp_img;

  typedef struct {
    logic        r0v;
    logic        r1v;
    logic        exp_id;
    logic [31:0] num;
    int          delay;
  } job_t;

  job_t jobs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present a request in IDLE, check the grant, then check the start pulse.
  task automatic accept(input logic r0v, input logic r1v, input logic exp_id);
    bus.req0_valid = r0v;
    bus.req1_valid = r1v;
    #1;
    check("req0_ready", bus.req0_ready, !exp_id);
    check("req1_ready", bus.req1_ready, exp_id);
    check("ready_excl", bus.req0_ready && bus.req1_ready, 1'b0);
    exp_img = exp_id ? IMG1 : IMG0;
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("net_valid_launch", bus.net_valid, 1'b1);
    check("busy_launch", bus.busy, 1'b1);
    check("net_img_latched", bus.net_img == exp_img, 1'b1);
  endtask

  // Wait delay cycles after the start pulse, then pulse net_ready.
  task automatic respond(input int delay, input logic [31:0] num);
    for (int i = 0; i < delay; i++) begin
      step();
      if (i == 0) check("net_valid_one_cycle", bus.net_valid, 1'b0);
      check("no_early_result", bus.res_valid, 1'b0);
    end
    check("net_img_held", bus.net_img == exp_img, 1'b1);
    bus.net_ready  = 1'b1;
    bus.net_number = num;
    step();
    bus.net_ready  = 1'b0;
    bus.net_number = '0;
  endtask

  task automatic check_result(input logic exp_id, input logic [31:0] num, input logic to);
    check("res_valid", bus.res_valid, 1'b1);
    check("res_id", bus.res_id, exp_id);
    check("res_number", bus.res_number, num);
    check("res_timeout", bus.res_timeout, to);
  endtask

  task automatic release_res();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("res_valid_dropped", bus.res_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "time limit");
  end

  initial begin
    int cnt;

    // Contention from reset alternates 0,1,0,1; then single requesters and
    // one more tie that rr_ptr resolves to requester 0.
    jobs[0] = '{r0v: 1'b1, r1v: 1'b1, exp_id: 1'b0, num: 32'd10,         delay: 1};
    jobs[1] = '{r0v: 1'b1, r1v: 1'b1, exp_id: 1'b1, num: 32'd11,         delay: 2};
    jobs[2] = '{r0v: 1'b1, r1v: 1'b1, exp_id: 1'b0, num: 32'hDEAD_BEEF,  delay: 1};
    jobs[3] = '{r0v: 1'b1, r1v: 1'b1, exp_id: 1'b1, num: 32'd13,         delay: 5};
    jobs[4] = '{r0v: 1'b1, r1v: 1'b0, exp_id: 1'b0, num: 32'd7,          delay: 3};
    jobs[5] = '{r0v: 1'b0, r1v: 1'b1, exp_id: 1'b1, num: 32'd21,         delay: 1};
    jobs[6] = '{r0v: 1'b1, r1v: 1'b1, exp_id: 1'b0, num: 32'h0000_0000,  delay: 4};

    bus.req0_valid = 1'b0;
    bus.req0_img   = IMG0;
    bus.req1_valid = 1'b0;
    bus.req1_img   = IMG1;
    bus.net_ready  = 1'b0;
    bus.net_number = '0;
    bus.res_ready  = 1'b0;
    exp_img        = '0;

    // Reset state
    step();
    step();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_net_valid", bus.net_valid, 1'b0);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_res_number", bus.res_number, 32'd0);
    check("rst_net_img_zero", bus.net_img == '0, 1'b1);
    check("rst_req0_ready", bus.req0_ready, 1'b0);
    rst = 1'b1;
    step();

    // Job table
    for (int j = 0; j < 7; j++) begin
      accept(jobs[j].r0v, jobs[j].r1v, jobs[j].exp_id);
      respond(jobs[j].delay, jobs[j].num);
      check_result(jobs[j].exp_id, jobs[j].num, 1'b0);
      release_res();
      check("idle_after_job", bus.busy, 1'b0);
    end

    // Timeout: no response, result 16 cycles after LAUNCH, then a guard
    // window in which a late done pulse and a request are both ignored.
    accept(1'b1, 1'b0, 1'b0);
    cnt = 0;
    while (!bus.res_valid && cnt < 40) begin
      step();
      cnt++;
    end
    check("timeout_latency", cnt, TIMEOUT_CYC);
    check_result(1'b0, 32'hFFFF_FFFF, 1'b1);
    release_res();
    check("guard_busy", bus.busy, 1'b1);
    bus.net_ready  = 1'b1;
    bus.net_number = 32'd5;
    bus.req0_valid = 1'b1;
    #1;
    check("guard_no_grant", bus.req0_ready, 1'b0);
    step();
    bus.net_ready  = 1'b0;
    bus.req0_valid = 1'b0;
    cnt = 1;
    while (bus.busy && cnt < 20) begin
      check("guard_no_result", bus.res_valid, 1'b0);
      step();
      cnt++;
    end
    check("guard_length", cnt, GUARD_CYC);
    for (int i = 0; i < 3; i++) begin
      check("post_guard_no_result", bus.res_valid, 1'b0);
      step();
    end

    // Backpressure: result held for 10 cycles while requester 1 waits.
    accept(1'b1, 1'b0, 1'b0);
    respond(1, 32'd55);
    check_result(1'b0, 32'd55, 1'b0);
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_req1_blocked", bus.req1_ready, 1'b0);
      check("bp_res_valid", bus.res_valid, 1'b1);
      check("bp_res_number", bus.res_number, 32'd55);
      step();
    end
    bus.res_ready = 1'b1;
    #1;
    check("bp_req1_blocked_at_ready", bus.req1_ready, 1'b0);
    step();
    bus.res_ready = 1'b0;
    check("bp_res_valid_dropped", bus.res_valid, 1'b0);
    accept(1'b0, 1'b1, 1'b1);
    respond(2, 32'd99);
    check_result(1'b1, 32'd99, 1'b0);
    release_res();

    // Race: net_ready in the very cycle the watchdog expires.
    accept(1'b1, 1'b0, 1'b0);
    respond(TIMEOUT_CYC - 1, 32'h0000_0042);
    check_result(1'b0, 32'h0000_0042, 1'b0);
    release_res();
    check("race_no_guard", bus.busy, 1'b0);

    // Reset in the middle of BUSY: job dropped, round-robin pointer cleared.
    accept(1'b1, 1'b0, 1'b0);
    step();
    step();
    check("pre_rst_busy", bus.busy, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_net_valid", bus.net_valid, 1'b0);
    check("mid_rst_res_valid", bus.res_valid, 1'b0);
    check("mid_rst_net_img_zero", bus.net_img == '0, 1'b1);
    step();
    rst = 1'b1;
    bus.net_ready  = 1'b1;
    bus.net_number = 32'd77;
    step();
    bus.net_ready  = 1'b0;
    bus.net_number = '0;
    for (int i = 0; i < 5; i++) begin
      check("post_rst_no_result", bus.res_valid, 1'b0);
      check("post_rst_no_start", bus.net_valid, 1'b0);
      step();
    end
    accept(1'b1, 1'b1, 1'b0);
    respond(1, 32'd123);
    check_result(1'b0, 32'd123, 1'b0);
    release_res();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
